// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the ALU/control
// code that issues its funct codes.
package mul_div_unit_pkg;

    localparam logic [5:0] FUNCT_MUL = 6'b011000;
    localparam logic [5:0] FUNCT_DIV = 6'b011010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mul_div_unit_restoring_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor if it fits, and report the quotient bit.
module mdu_restoring_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < divisor always holds, so the shifted value needs one extra bit
    // and the restored remainder fits back into WIDTH bits.
    assign shifted = {rem_in, dividend_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: one bit per cycle, busy while
// iterating, single-cycle done pulse with {hi,lo} result and error flags.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [5:0]         funct,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               div_by_zero,
    output logic               illegal,
    output logic [1:0]         state_dbg
);

    // Handshake: start is accepted only in IDLE or DONE (busy==0); done is a
    // one-cycle pulse and result/flags are valid in that cycle and held after.

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CW-1:0]    cnt;
    logic             last_iter;
    logic             idle_like;

    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;

    logic [WIDTH-1:0] div_rem_next;
    logic             div_q_bit;
    logic [WIDTH-1:0] div_lo_next;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // Shift-add multiply: acc_lo starts as the multiplier and drains LSB first
    // while product bits shift in from the top.
    assign mul_addend  = acc_lo[0] ? a_r : '0;
    assign mul_sum     = {1'b0, acc_hi} + {1'b0, mul_addend};
    assign mul_hi_next = mul_sum[WIDTH:1];
    assign mul_lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // Restoring divide: acc_hi is the remainder, acc_lo shifts the dividend
    // out MSB first and the quotient in at the bottom.
    mdu_restoring_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_in       (acc_hi),
        .dividend_bit (acc_lo[WIDTH-1]),
        .divisor      (b_r),
        .rem_out      (div_rem_next),
        .q_bit        (div_q_bit)
    );

    assign div_lo_next = {acc_lo[WIDTH-2:0], div_q_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (funct == FUNCT_MUL) begin
                        state_next = MUL;
                    end else if ((funct == FUNCT_DIV) && (b != '0)) begin
                        state_next = DIV;
                    end else begin
                        state_next = DONE;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            MUL, DIV: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r         <= '0;
            b_r         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            cnt         <= '0;
            result      <= '0;
            div_by_zero <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_r         <= a;
                        b_r         <= b;
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                        illegal     <= 1'b0;
                        acc_hi      <= '0;
                        if (funct == FUNCT_MUL) begin
                            acc_lo <= b;
                        end else if (funct == FUNCT_DIV) begin
                            acc_lo <= a;
                            if (b == '0) begin
                                result      <= {a, {WIDTH{1'b1}}};
                                div_by_zero <= 1'b1;
                            end
                        end else begin
                            result  <= '0;
                            illegal <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_hi <= mul_hi_next;
                    acc_lo <= mul_lo_next;
                    cnt    <= cnt + CW'(1);
                    if (last_iter) begin
                        result <= {mul_hi_next, mul_lo_next};
                    end
                end
                DIV: begin
                    acc_hi <= div_rem_next;
                    acc_lo <= div_lo_next;
                    cnt    <= cnt + CW'(1);
                    if (last_iter) begin
                        result <= {div_rem_next, div_lo_next};
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    assign busy      = (state == MUL) || (state == DIV);
    assign done      = (state == DONE);
    assign hi        = result[2*WIDTH-1:WIDTH];
    assign lo        = result[WIDTH-1:0];
    assign state_dbg = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: driver pushes expected responses, a monitor
// pops and compares them whenever done pulses.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int W = 16;

    typedef struct packed {
        logic [2*W-1:0] res;
        logic [1:0]     flg;   // {div_by_zero, illegal}
        logic [15:0]    t0;
        logic [7:0]     lat;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           start;
    logic [5:0]     funct;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic           div_by_zero;
    logic           illegal;
    logic [1:0]     state_dbg;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .funct       (funct),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero),
        .illegal     (illegal),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver: assumes it is called at a negedge; holds start for one cycle
    task automatic issue(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit push, input logic [2*W-1:0] er, input logic [1:0] ef,
                         input int el);
        exp_t e;
        start = 1'b1;
        funct = f;
        a     = x;
        b     = y;
        if (push) begin
            e.res = er;
            e.flg = ef;
            e.t0  = cyc[15:0];
            e.lat = el[7:0];
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        funct = 6'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    task automatic wait_done(input int max_cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("done_timeout", {31'd0, seen}, 32'd1);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", result, mon_e.res);
                chk("hi", {16'd0, hi}, {16'd0, mon_e.res[2*W-1:W]});
                chk("lo", {16'd0, lo}, {16'd0, mon_e.res[W-1:0]});
                chk("flags", {30'd0, div_by_zero, illegal}, {30'd0, mon_e.flg});
                chk("latency", cyc - int'(mon_e.t0), {24'd0, mon_e.lat});
            end
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        funct = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {30'd0, div_by_zero, illegal}, 32'd0);
        chk("rst_state", {30'd0, state_dbg}, 32'd0);
        rst = 1'b0;

        @(negedge clk); issue(FUNCT_MUL, 16'h0003, 16'h0005, 1, 32'h0000_000F, 2'b00, 17);
        wait_done(40);
        @(negedge clk); issue(FUNCT_MUL, 16'hFFFF, 16'hFFFF, 1, 32'hFFFE_0001, 2'b00, 17);
        wait_done(40);
        @(negedge clk); issue(FUNCT_DIV, 16'd100, 16'd7, 1, 32'h0002_000E, 2'b00, 17);
        wait_done(40);

        @(negedge clk); issue(FUNCT_DIV, 16'h1234, 16'h0000, 1, 32'h1234_FFFF, 2'b10, 1);
        chk("div0_busy", {31'd0, busy}, 32'd0);
        wait_done(5);
        @(negedge clk); issue(6'b100000, 16'hABCD, 16'h1111, 1, 32'h0000_0000, 2'b01, 1);
        chk("illegal_busy", {31'd0, busy}, 32'd0);
        wait_done(5);

        // start while busy is ignored; then back-to-back issue in the DONE cycle
        @(negedge clk); issue(FUNCT_MUL, 16'd7, 16'd9, 1, 32'h0000_003F, 2'b00, 17);
        repeat (4) @(negedge clk);
        start = 1'b1; funct = FUNCT_DIV; a = 16'd50; b = 16'd5;
        @(negedge clk);
        start = 1'b0;
        chk("busy_during_mul", {31'd0, busy}, 32'd1);
        wait_done(40);
        issue(FUNCT_DIV, 16'd50, 16'd5, 1, 32'h0000_000A, 2'b00, 17);
        wait_done(40);

        @(negedge clk); issue(FUNCT_DIV, 16'hFFFF, 16'h0001, 1, 32'h0000_FFFF, 2'b00, 17);
        wait_done(40);
        @(negedge clk); issue(FUNCT_DIV, 16'd5, 16'd9, 1, 32'h0005_0000, 2'b00, 17);
        wait_done(40);
        @(negedge clk); issue(FUNCT_MUL, 16'h1234, 16'h0000, 1, 32'h0000_0000, 2'b00, 17);
        wait_done(40);
        @(negedge clk); issue(FUNCT_MUL, 16'h8000, 16'h0002, 1, 32'h0001_0000, 2'b00, 17);
        wait_done(40);

        // reset mid-divide aborts without a done pulse
        @(negedge clk); issue(FUNCT_DIV, 16'd1000, 16'd3, 0, '0, 2'b00, 0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        rst = 1'b0;
        repeat (25) @(negedge clk);

        @(negedge clk); issue(FUNCT_MUL, 16'd3, 16'd5, 1, 32'h0000_000F, 2'b00, 17);
        wait_done(40);

        repeat (3) @(negedge clk);
        chk("pending_left", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
